// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - register map, FSM states and STAT layout shared by irq_ctrl
package irq_pkg;

  localparam logic [1:0] REG_MASK = 2'd0;
  localparam logic [1:0] REG_EDGE = 2'd1;
  localparam logic [1:0] REG_PEND = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  localparam int STAT_INSVC_BIT = 31;
  localparam int STAT_REQ_BIT   = 30;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - lowest-index-wins priority encoder over the candidate lines
module irq_prio_enc #(
  parameter int N = 6,
  parameter int W = 3
) (
  input  logic [N-1:0] cand_i,
  output logic [W-1:0] sel_o,
  output logic         any_o
);

  // Scan from the top so the lowest set index is the last assignment standing.
  always_comb begin
    sel_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cand_i[i]) sel_o = W'(i);
    end
  end

  assign any_o = |cand_i;

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - priority interrupt controller with mask/edge/pend registers and
// a request/ack/eret handshake towards CP0
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int NUM_IRQ = 6,
  parameter int CODE_W  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               we,
  input  logic [1:0]         addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               int_req,
  output logic [CODE_W-1:0]  int_code,
  input  logic               int_ack,
  input  logic               eret
);

  localparam int CODE_SPAN = 2 ** CODE_W;

  irq_state_e          state_q, state_d;
  logic [NUM_IRQ-1:0]  mask_q, mask_d;
  logic [NUM_IRQ-1:0]  edge_q, edge_d;
  logic [NUM_IRQ-1:0]  pend_q, pend_d;
  logic [NUM_IRQ-1:0]  irq_q;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [CODE_W-1:0]   svc_id_q, svc_id_d;

  logic [NUM_IRQ-1:0]  rise, w1c, ack_clr, cand;
  logic [CODE_SPAN-1:0] cand_pad, edge_pad;
  logic [CODE_W-1:0]   sel;
  logic                any;
  logic                take;
  logic                unused_wdata;

  assign unused_wdata = ^wdata[31:NUM_IRQ];

  assign rise     = irq_in & ~irq_q;
  assign w1c      = (we && addr == REG_PEND) ? wdata[NUM_IRQ-1:0] : '0;
  assign cand     = pend_q & mask_q;
  assign cand_pad = CODE_SPAN'(cand);
  assign edge_pad = CODE_SPAN'(edge_q);
  assign take     = (state_q == REQ) && int_ack;
  assign ack_clr  = (take && edge_pad[code_q]) ? (NUM_IRQ'(1) << code_q) : '0;

  irq_prio_enc #(
    .N (NUM_IRQ),
    .W (CODE_W)
  ) u_prio_enc (
    .cand_i (cand),
    .sel_o  (sel),
    .any_o  (any)
  );

  // Edge lines: set beats W1C, the ack clear beats set. Level lines mirror the input.
  assign pend_d = (edge_q & (((pend_q & ~w1c) | rise) & ~ack_clr))
                | (~edge_q & irq_in);
  assign mask_d = (we && addr == REG_MASK) ? wdata[NUM_IRQ-1:0] : mask_q;
  assign edge_d = (we && addr == REG_EDGE) ? wdata[NUM_IRQ-1:0] : edge_q;

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    svc_id_d = svc_id_q;
    case (state_q)
      IDLE: begin
        if (any) begin
          state_d = REQ;
          code_d  = sel;
        end
      end
      REQ: begin
        if (int_ack) begin
          state_d  = SERVICE;
          svc_id_d = code_q;
        end else if (!cand_pad[code_q]) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (eret) begin
          state_d  = IDLE;
          svc_id_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      edge_q   <= '0;
      pend_q   <= '0;
      irq_q    <= '0;
      code_q   <= '0;
      svc_id_q <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      edge_q   <= edge_d;
      pend_q   <= pend_d;
      irq_q    <= irq_in;
      code_q   <= code_d;
      svc_id_q <= svc_id_d;
    end
  end

  assign int_req  = (state_q == REQ);
  assign int_code = code_q;

  always_comb begin
    rdata = '0;
    case (addr)
      REG_MASK: rdata[NUM_IRQ-1:0] = mask_q;
      REG_EDGE: rdata[NUM_IRQ-1:0] = edge_q;
      REG_PEND: rdata[NUM_IRQ-1:0] = pend_q;
      REG_STAT: begin
        rdata[STAT_INSVC_BIT] = (state_q == SERVICE);
        rdata[STAT_REQ_BIT]   = int_req;
        rdata[CODE_W-1:0]     = svc_id_q;
      end
      default: rdata = '0;
    endcase
  end

endmodule
